// File: rtl/video_pkg.sv
// Shared video timing constants, sync polarities and window helpers.
package video_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam logic SYNC_ACT_LOW  = 1'b0;
  localparam logic SYNC_ACT_HIGH = 1'b1;

  localparam int SUB_W = 3;

  function automatic int win_off(input int disp, input int fac);
    if (fac < 1) return 0;
    return (disp - (disp / fac) * fac) / 2;
  endfunction

  function automatic int pos_w(input int disp, input int fac);
    int n;
    if (fac < 1) return 1;
    n = $clog2(disp / fac);
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One timing axis: raw counter, sync/active decode and scaled
// window sub-counter plus logical position.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int DISPLAY  = VGA_H_DISPLAY,
  parameter int FRONT    = VGA_H_FRONT,
  parameter int SYNC_LEN = VGA_H_SYNC,
  parameter int BACK     = VGA_H_BACK,
  parameter int FACTOR   = 4,
  parameter int CNT_W    = $clog2(DISPLAY + FRONT + SYNC_LEN + BACK),
  parameter int POS_W    = pos_w(DISPLAY, FACTOR)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             active_o,
  output logic             in_win_o,
  output logic [SUB_W-1:0] sub_o,
  output logic [POS_W-1:0] pos_o
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC_LEN + BACK;
  localparam int FAC   = (FACTOR < 1) ? 1 : FACTOR;
  localparam int LN    = DISPLAY / FAC;

  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] OFF_C  = CNT_W'(win_off(DISPLAY, FAC));
  localparam logic [CNT_W-1:0] WIN_C  = CNT_W'(LN * FAC);
  localparam logic [CNT_W-1:0] SYN_C  = CNT_W'(DISPLAY + FRONT);
  localparam logic [CNT_W-1:0] SLEN_C = CNT_W'(SYNC_LEN);
  localparam logic [CNT_W-1:0] DISP_C = CNT_W'(DISPLAY);
  localparam logic [SUB_W-1:0] SUB_MX = SUB_W'(FAC - 1);

  if (FACTOR < 1 || FACTOR > 8 || FACTOR > DISPLAY) begin : g_bad_factor
    $error("video_axis_counter: FACTOR %0d illegal (DISPLAY %0d)",
           FACTOR, DISPLAY);
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             wrap;
  logic             nxt_in;

  assign wrap  = cnt_q == LAST_C;
  assign cnt_d = !adv_i ? cnt_q
               : (wrap ? '0 : cnt_q + CNT_W'(1));

  // Offset subtraction wraps below the base, so one compare covers both bounds.
  assign nxt_in   = (cnt_d - OFF_C) < WIN_C;
  assign in_win_o = (cnt_q - OFF_C) < WIN_C;
  assign sync_o   = (cnt_q - SYN_C) < SLEN_C;
  assign active_o = cnt_q < DISP_C;

  always_comb begin
    sub_d = sub_q;
    pos_d = pos_q;
    if (adv_i) begin
      if (cnt_d == OFF_C) begin
        sub_d = '0;
        pos_d = '0;
      end else if (nxt_in) begin
        if (sub_q == SUB_MX) begin
          sub_d = '0;
          pos_d = pos_q + POS_W'(1);
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sub_q <= '0;
      pos_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sub_q <= sub_d;
      pos_q <= pos_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap;
  assign sub_o  = sub_q;
  assign pos_o  = pos_q;

endmodule

// File: rtl/video_timing_scaler.sv
// VGA timing generator with independent integer H/V scaling and centred
// border; define VIDEO_SCANLINES_EN to blank the last line of each row.
module video_timing_scaler
  import video_pkg::*;
#(
  parameter int   H_DISPLAY = VGA_H_DISPLAY,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_DISPLAY = VGA_V_DISPLAY,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter int   H_FACTOR  = 4,
  parameter int   V_FACTOR  = 4,
  parameter logic SYNC_POL  = SYNC_ACT_LOW,
  localparam int  HPOS_W    = pos_w(H_DISPLAY, H_FACTOR),
  localparam int  VPOS_W    = pos_w(V_DISPLAY, V_FACTOR)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic              border,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              pix_strobe,
  output logic              row_strobe,
  output logic              frame_start
);

  localparam int H_CW = $clog2(H_DISPLAY + H_FRONT + H_SYNC + H_BACK);
  localparam int V_CW = $clog2(V_DISPLAY + V_FRONT + V_SYNC + V_BACK);

  logic [H_CW-1:0]   h_cnt;
  logic [V_CW-1:0]   v_cnt;
  logic [SUB_W-1:0]  h_sub, v_sub;
  logic [HPOS_W-1:0] h_pos;
  logic [VPOS_W-1:0] v_pos;
  logic h_wrap, h_sync, h_act, h_win;
  logic v_wrap, v_sync, v_act, v_win;
  logic mask, in_win;
  logic unused_v_wrap;

  video_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC_LEN(H_SYNC),
    .BACK(H_BACK), .FACTOR(H_FACTOR),
    .CNT_W(H_CW), .POS_W(HPOS_W)
  ) u_h (
    .clk_i(clk), .rst_ni(reset), .adv_i(1'b1),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .sync_o(h_sync),
    .active_o(h_act), .in_win_o(h_win),
    .sub_o(h_sub), .pos_o(h_pos)
  );

  video_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC_LEN(V_SYNC),
    .BACK(V_BACK), .FACTOR(V_FACTOR),
    .CNT_W(V_CW), .POS_W(VPOS_W)
  ) u_v (
    .clk_i(clk), .rst_ni(reset), .adv_i(h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .sync_o(v_sync),
    .active_o(v_act), .in_win_o(v_win),
    .sub_o(v_sub), .pos_o(v_pos)
  );

  assign unused_v_wrap = v_wrap;
  assign in_win        = h_win && v_win;

`ifdef VIDEO_SCANLINES_EN
  if (V_FACTOR >= 2) begin : g_scan
    assign mask = v_sub == SUB_W'(V_FACTOR - 1);
  end else begin : g_noscan
    assign mask = 1'b0;
  end
`else
  assign mask = 1'b0;
`endif

  logic hsync_d, vsync_d, de_d, bd_d, ps_d, rs_d, fs_d;
  logic hsync_q, vsync_q, de_q, bd_q, ps_q, rs_q, fs_q;
  logic [HPOS_W-1:0] hpos_d, hpos_q;
  logic [VPOS_W-1:0] vpos_d, vpos_q;

  always_comb begin
    hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
    vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
    de_d    = in_win && !mask;
    bd_d    = h_act && v_act && !in_win;
    ps_d    = in_win && (h_sub == '0);
    rs_d    = ps_d && (h_pos == '0) && (v_sub == '0);
    fs_d    = (h_cnt == '0) && (v_cnt == '0);
    hpos_d  = h_pos;
    vpos_d  = v_pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      bd_q    <= 1'b0;
      ps_q    <= 1'b0;
      rs_q    <= 1'b0;
      fs_q    <= 1'b0;
      hpos_q  <= '0;
      vpos_q  <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      bd_q    <= bd_d;
      ps_q    <= ps_d;
      rs_q    <= rs_d;
      fs_q    <= fs_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = de_q;
  assign border      = bd_q;
  assign pix_strobe  = ps_q;
  assign row_strobe  = rs_q;
  assign frame_start = fs_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;

endmodule

// File: tb/tb_video_timing_scaler.sv
// Bench: reduced timing, 6x4 scaled instance with border and 1x1
// active-high-sync instance, directed points plus per-cycle model.
module tb_video_timing_scaler;

  localparam int HD = 20, HF = 2, HS = 3, HB = 3, HT = 28;
  localparam int VD = 14, VF = 1, VS = 2, VB = 3, VT = 20;
`ifdef VIDEO_SCANLINES_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  localparam int S_FS = 0, S_PS = 1, S_RS = 2, S_HP = 3, S_VP = 4;
  localparam int S_DE = 5, S_BD = 6, S_HS = 7, S_VS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_hs, a_vs, a_de, a_bd, a_ps, a_rs, a_fs;
  logic [1:0] a_hp, a_vp;
  logic b_hs, b_vs, b_de, b_bd, b_ps, b_rs, b_fs;
  logic [4:0] b_hp;
  logic [3:0] b_vp;

  video_timing_scaler #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_FACTOR(6), .V_FACTOR(4), .SYNC_POL(1'b0)
  ) u_a (
    .clk(clk), .reset(rst_n), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .border(a_bd), .hpos(a_hp), .vpos(a_vp),
    .pix_strobe(a_ps), .row_strobe(a_rs), .frame_start(a_fs)
  );

  video_timing_scaler #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_FACTOR(1), .V_FACTOR(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(rst_n), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .border(b_bd), .hpos(b_hp), .vpos(b_vp),
    .pix_strobe(b_ps), .row_strobe(b_rs), .frame_start(b_fs)
  );

  typedef struct {
    logic hs, vs, de, bd, ps, rs, fs;
    logic [31:0] hp, vp;
  } out_t;

  typedef struct packed { int b, h, v, sel, val; } vec_t;

  localparam int NV = 31;
  vec_t tbl [NV] = '{
    '{0, 0, 0, S_FS, 1}, '{0, 0, 0, S_BD, 1}, '{0, 1, 1, S_RS, 1},
    '{0, 1, 1, S_DE, 1}, '{0, 7, 1, S_PS, 1}, '{0, 7, 1, S_HP, 1},
    '{0, 7, 1, S_RS, 0}, '{0, 18, 1, S_HP, 2}, '{0, 19, 1, S_BD, 1},
    '{0, 21, 1, S_HS, 1}, '{0, 22, 1, S_HS, 0}, '{0, 24, 1, S_HS, 0},
    '{0, 25, 1, S_HS, 1}, '{0, 1, 5, S_RS, 1}, '{0, 1, 5, S_VP, 1},
    '{0, 1, 4, S_DE, SCAN ? 0 : 1}, '{0, 1, 4, S_BD, 0},
    '{0, 3, 13, S_BD, 1}, '{0, 3, 13, S_VP, 2}, '{0, 0, 15, S_VS, 0},
    '{0, 0, 17, S_VS, 1},
    '{1, 0, 1, S_PS, 1}, '{1, 0, 1, S_RS, 1}, '{1, 1, 1, S_RS, 0},
    '{1, 19, 2, S_HP, 19}, '{1, 19, 2, S_PS, 1}, '{1, 19, 2, S_BD, 0},
    '{1, 20, 2, S_DE, 0}, '{1, 22, 2, S_HS, 1}, '{1, 5, 13, S_VP, 13},
    '{1, 5, 14, S_DE, 0}
  };

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int n,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0d: got %0d want %0d", tag, n, got, want);
    end
  endtask

  function automatic logic [31:0] b32(input logic x);
    return {31'b0, x};
  endfunction

  function automatic out_t obs_a();
    out_t o;
    o.hs = a_hs; o.vs = a_vs; o.de = a_de; o.bd = a_bd;
    o.ps = a_ps; o.rs = a_rs; o.fs = a_fs;
    o.hp = 32'(a_hp); o.vp = 32'(a_vp);
    return o;
  endfunction

  function automatic out_t obs_b();
    out_t o;
    o.hs = b_hs; o.vs = b_vs; o.de = b_de; o.bd = b_bd;
    o.ps = b_ps; o.rs = b_rs; o.fs = b_fs;
    o.hp = 32'(b_hp); o.vp = 32'(b_vp);
    return o;
  endfunction

  // Expected outputs for the n-th counter state after reset release.
  function automatic out_t model(input int n, input int hf, input int vf,
                                 input logic pol);
    out_t o;
    int h, v, lw, lh, ho, vo, hsub, vsub;
    bit hw, vw, mask;
    h = n % HT;
    v = (n / HT) % VT;
    lw = HD / hf; lh = VD / vf;
    ho = (HD - lw * hf) / 2; vo = (VD - lh * vf) / 2;
    hw = h >= ho && h < ho + lw * hf;
    vw = v >= vo && v < vo + lh * vf;
    hsub = hw ? (h - ho) % hf : 0;
    vsub = vw ? (v - vo) % vf : 0;
    if (hw) o.hp = (h - ho) / hf;
    else if (h < ho && n < HT) o.hp = 0;
    else o.hp = lw - 1;
    if (vw) o.vp = (v - vo) / vf;
    else if (v < vo && n < HT * VT) o.vp = 0;
    else o.vp = lh - 1;
    mask = SCAN && vf >= 2 && vsub == vf - 1;
    o.ps = hw && vw && hsub == 0;
    o.rs = o.ps && o.hp == 0 && vsub == 0;
    o.de = hw && vw && !mask;
    o.bd = h < HD && v < VD && !(hw && vw);
    o.hs = (h >= HD + HF && h < HD + HF + HS) ? pol : ~pol;
    o.vs = (v >= VD + VF && v < VD + VF + VS) ? pol : ~pol;
    o.fs = h == 0 && v == 0;
    return o;
  endfunction

  function automatic logic [31:0] sel_of(input out_t o, input int s);
    case (s)
      S_FS: return b32(o.fs);
      S_PS: return b32(o.ps);
      S_RS: return b32(o.rs);
      S_HP: return o.hp;
      S_VP: return o.vp;
      S_DE: return b32(o.de);
      S_BD: return b32(o.bd);
      S_HS: return b32(o.hs);
      default: return b32(o.vs);
    endcase
  endfunction

  task automatic cmp_all(input string who, input int n,
                         input out_t g, input out_t w);
    check({who, "_hsync"}, n, b32(g.hs), b32(w.hs));
    check({who, "_vsync"}, n, b32(g.vs), b32(w.vs));
    check({who, "_display_on"}, n, b32(g.de), b32(w.de));
    check({who, "_border"}, n, b32(g.bd), b32(w.bd));
    check({who, "_pix_strobe"}, n, b32(g.ps), b32(w.ps));
    check({who, "_row_strobe"}, n, b32(g.rs), b32(w.rs));
    check({who, "_frame_start"}, n, b32(g.fs), b32(w.fs));
    check({who, "_hpos"}, n, g.hp, w.hp);
    check({who, "_vpos"}, n, g.vp, w.vp);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_a_hsync"}, 0, b32(a_hs), 1);
    check({tag, "_a_vsync"}, 0, b32(a_vs), 1);
    check({tag, "_a_display_on"}, 0, b32(a_de), 0);
    check({tag, "_a_border"}, 0, b32(a_bd), 0);
    check({tag, "_a_pix_strobe"}, 0, b32(a_ps), 0);
    check({tag, "_a_row_strobe"}, 0, b32(a_rs), 0);
    check({tag, "_a_frame_start"}, 0, b32(a_fs), 0);
    check({tag, "_a_hpos"}, 0, 32'(a_hp), 0);
    check({tag, "_a_vpos"}, 0, 32'(a_vp), 0);
    check({tag, "_b_hsync"}, 0, b32(b_hs), 0);
    check({tag, "_b_vsync"}, 0, b32(b_vs), 0);
    check({tag, "_b_hpos"}, 0, 32'(b_hp), 0);
  endtask

  task automatic sweep(input int cycles);
    out_t ga, gb;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      ga = obs_a();
      gb = obs_b();
      cmp_all("A", n, ga, model(n, 6, 4, 1'b0));
      cmp_all("B", n, gb, model(n, 1, 1, 1'b1));
      if (n < HT * VT) begin
        for (int i = 0; i < NV; i++) begin
          if (n == tbl[i].v * HT + tbl[i].h)
            check($sformatf("vec%0d", i), n,
                  sel_of(tbl[i].b != 0 ? gb : ga, tbl[i].sel),
                  32'(tbl[i].val));
        end
      end
    end
  endtask

  initial begin
    int  n;
    bit  found;
    repeat (10) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    sweep(HT * VT + 2 * HT);

    n = HT * VT + 2 * HT;
    found = 1'b0;
    for (int k = 0; k < HT * VT; k++) begin
      @(posedge clk);
      @(negedge clk);
      if ((n % HT) == 10 && ((n / HT) % VT) == 7) begin
        found = 1'b1;
        break;
      end
      n++;
    end
    check("mid_reached", n, b32(found), 1);
    cmp_all("A_mid", n, obs_a(), model(n, 6, 4, 1'b0));

    rst_n = 1'b0;
    #1;
    chk_reset("async");
    repeat (3) @(negedge clk);
    chk_reset("held");
    rst_n = 1'b1;
    sweep(HT * VT + HT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_scaler.md
# video_timing_scaler

Generalised VGA timing generator plus integer pixel scaler. It produces sync, logical pixel coordinates and fetch strobes for a logical framebuffer. Horizontal and vertical factors are independent and need not be powers of two. Leftover physical pixels are centred as a border. Sits between the pixel clock and the framebuffer/sprite fetch logic, replacing the fixed power-of-two scaler.

## Interface
- H_DISPLAY, 640: active physical columns; H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal porches/sync
- V_DISPLAY, 480: active physical lines; V_FRONT 10, V_SYNC 2, V_BACK 33: vertical porches/sync
- H_FACTOR, 4: physical columns per logical pixel, 1..8
- V_FACTOR, 4: physical lines per logical row, 1..8
- SYNC_POL, 1'b0: active level of hsync/vsync (0 = active-low)
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low; clears all state
- hsync  out  1  horizontal sync, SYNC_POL active
- vsync  out  1  vertical sync, SYNC_POL active
- display_on  out  1  physical pixel inside scaled window (scanline mask applied)
- border  out  1  inside active area but outside scaled window
- hpos  out  HPOS_W  logical column, HPOS_W = max(1, $clog2(H_DISPLAY/H_FACTOR))
- vpos  out  VPOS_W  logical row, VPOS_W = max(1, $clog2(V_DISPLAY/V_FACTOR))
- pix_strobe  out  1  first physical column of each logical pixel in window
- row_strobe  out  1  first physical column of window on first physical line of each logical row
- frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0

## Operation
- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), wraps to 0 and advances vcnt 0..V_TOTAL-1, which wraps to 0.
- Window: LW = H_DISPLAY/H_FACTOR (floor), H_OFF = (H_DISPLAY - LW*H_FACTOR)/2. LH and V_OFF are defined the same way. The odd remainder pixel goes right/bottom.
- hsync is active for hcnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC). vsync is defined the same way on vcnt.
- hsub (0..H_FACTOR-1) and hpos:
  - Both cleared at hcnt = H_OFF.
  - Inside the window, hsub increments each cycle. On wrap, hpos increments.
  - Outside the window, both hold.
- vsub and vpos behave the same way, advanced on hcnt wrap within the vertical window and cleared at vcnt = V_OFF.
- hpos/vpos hold their last in-window value outside the window. They never exceed LW-1/LH-1.
- pix_strobe = in_window && hsub==0.
- row_strobe = pix_strobe && hpos==0 && vsub==0.
- display_on = in_window && !mask. border = active && !in_window.
- H_FACTOR=1 degenerates to hpos = hcnt - H_OFF with pix_strobe high throughout the window.
- Illegal parameters (factor 0 or >8, factor > display): elaboration-time $error.

## Timing
- All outputs are registered and reflect counter state with one cycle latency. Latency is identical for every output, so alignment is exact.
- Reset values: hsync = vsync = !SYNC_POL; display_on, border, pix_strobe, row_strobe, frame_start = 0; hpos = vpos = 0; counters 0.
- First cycle after reset release: counters at 0. frame_start is asserted on the following edge, for one cycle per frame thereafter.
- Reset asserted mid-frame: outputs go to reset values immediately (async). No partial-frame recovery; the frame restarts from hcnt=0.
- Frame wrap and line wrap occurring on the same edge: vcnt wraps and hcnt wraps together. Sub-counters clear with no extra cycle.

## Configuration
- VIDEO_SCANLINES_EN defined:
  - mask = (vsub == V_FACTOR-1) when V_FACTOR ≥ 2, else 0.
  - display_on is low on the last physical line of each logical row.
  - border is unaffected.
- Undefined: mask = 0. No extra logic.

## Structure
- Shared package video_pkg holds:
  - default VGA 640x480 timing constants;
  - sync polarity constants;
  - a function computing window offset from display size and factor.
- Sub-module video_axis_counter, instantiated twice (H and V):
  - inputs: advance enable;
  - parameters: display/porch/sync/factor;
  - outputs: raw count, wrap, sync, active, in_window, sub, logical position.

## Test plan
- Reset held low 10 cycles, released:
  - during reset, hsync = vsync = 1 (SYNC_POL=0) and display_on = 0;
  - first frame_start is 1 cycle after release;
  - frame_start recurs every 800*525 = 420000 cycles.
- Defaults (4x4), VIDEO_SCANLINES_EN undefined:
  - hpos counts 0..159 with pix_strobe every 4 cycles and border = 0;
  - vpos counts 0..119;
  - hsync low for exactly 96 cycles starting at hcnt=656.
- H_FACTOR=6, V_FACTOR=3:
  - LW=106, H_OFF=2; border high for hcnt 0,1 and 638,639;
  - first pix_strobe at hcnt=2; hpos max 105;
  - vpos max 159, border = 0 vertically.
- VIDEO_SCANLINES_EN defined, V_FACTOR=4: display_on low on vcnt 3, 7, 11, ... within the window and high on the other lines; border unchanged.
- Reset asserted at vcnt=200, hcnt=300 for 3 cycles:
  - outputs return to reset values asynchronously in the same cycle;
  - after release the full frame restarts with vpos=0 at vcnt=0.
- H_FACTOR=1, V_FACTOR=1: hpos = 0..639, pix_strobe high for all 640 active cycles; row_strobe once per line at hcnt=0.
